clk_pin_conditioner: RTL and testbench

- Front-end stage of the clock-recovery path. Produces the per-pin edge events consumed by event_detection.
- Synchronizes the raw recovery pins (primary, secondary) into the sys domain and deglitches each with a stable-level filter.
- Emits single-cycle rising/falling/either edge pulses per pin as a clks_alot_p::driver_events_s.
- Also reports glitches, meaning rejected short pulses, for diagnostics.

---
 rtl/clk_pin_conditioner_pkg.sv | 18 +
 rtl/clks_alot_p.sv | 23 ++
 rtl/common_p.sv | 9 +
 rtl/clk_pin_conditioner_if.sv | 9 +
 rtl/clk_pin_filter.sv | 71 +++++++
 rtl/clk_pin_conditioner.sv | 163 ++++++++++++++++
 tb/tb_clk_pin_conditioner.sv | 322 ++++++++++++++++++++++++++++++++
 7 files changed

// File: rtl/clk_pin_conditioner_pkg.sv
// Types local to the pin conditioner: per-pin filter result and skew-aligner sizing.
package clk_pin_conditioner_pkg;

    // Countdown width for the optional skew aligner (SKEW_WINDOW up to 15).
    localparam int unsigned SKEW_CNT_W = 4;

    // rise_c/fall_c are the edge strobes the top registers; glitch and level come from flops.
    typedef struct packed {
        logic rise_c;
        logic fall_c;
        logic glitch;
        logic level;
    } pin_evt_s;

    // {rise, fall} pair for one pin.
    typedef logic [1:0] edge_pair_t;

endpackage

// File: rtl/clks_alot_p.sv
// Clock-recovery types and defaults shared by the recovery front end and event_detection.
package clks_alot_p;

    localparam int unsigned CLK_COND_SYNC_STAGES_DEFAULT   = 2;
    localparam int unsigned CLK_COND_FILTER_CYCLES_DEFAULT = 3;

    typedef logic [7:0] filter_cnt_t;

    typedef struct packed {
        logic secondary;
        logic primary;
    } recovery_pins_s;

    typedef struct packed {
        logic primary_rising_edge;
        logic primary_falling_edge;
        logic primary_either_edge;
        logic secondary_rising_edge;
        logic secondary_falling_edge;
        logic secondary_either_edge;
    } driver_events_s;

endpackage

// File: rtl/common_p.sv
// Shared clocking types: a clock/reset bundle handed to every block in a domain.
package common_p;

    typedef struct packed {
        logic clk;
        logic rst_n;
    } clk_dom_s;

endpackage

// File: rtl/clk_pin_conditioner_if.sv
// Per-pin result bundle from a clk_pin_filter (master) to the conditioner top (slave).
interface clk_pin_conditioner_if;
    import clk_pin_conditioner_pkg::*;

    pin_evt_s evt;

    modport master (output evt);
    modport slave  (input  evt);
endinterface

// File: rtl/clk_pin_filter.sv
// One recovery pin: synchronizer chain, stable-level filter, edge strobe and glitch flag.
module clk_pin_filter
    import clks_alot_p::*;
#(
    parameter int unsigned SYNC_STAGES   = CLK_COND_SYNC_STAGES_DEFAULT,
    parameter int unsigned FILTER_CYCLES = CLK_COND_FILTER_CYCLES_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en_i,
    input  logic                         pin_i,
    clk_pin_conditioner_if.master        evt_if
);

    localparam filter_cnt_t CNT_LAST = filter_cnt_t'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_lvl;
    logic                   filt_q, filt_d;
    filter_cnt_t            cnt_q, cnt_d;
    logic                   chg_q, chg_d;
    logic                   glitch_q, glitch_d;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Next-state: shift the synchronizer, then qualify the synchronized level.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], pin_i};
        filt_d   = filt_q;
        cnt_d    = '0;
        chg_d    = 1'b0;
        glitch_d = 1'b0;
        if (!en_i) begin
            // Track silently so enabling can never fire on a stale level.
            filt_d = sync_lvl;
        end else if (sync_lvl == filt_q) begin
            glitch_d = (cnt_q != '0);
        end else if (cnt_q == CNT_LAST) begin
            filt_d = sync_lvl;
            chg_d  = 1'b1;
        end else begin
            cnt_d = cnt_q + filter_cnt_t'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            filt_q   <= 1'b0;
            cnt_q    <= '0;
            chg_q    <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            filt_q   <= filt_d;
            cnt_q    <= cnt_d;
            chg_q    <= chg_d;
            glitch_q <= glitch_d;
        end
    end

    // Edge strobes land the cycle after the accepted level changes.
    always_comb begin
        evt_if.evt.rise_c = en_i & chg_q & filt_q;
        evt_if.evt.fall_c = en_i & chg_q & ~filt_q;
        evt_if.evt.glitch = glitch_q;
        evt_if.evt.level  = filt_q;
    end

endmodule

// File: rtl/clk_pin_conditioner.sv
// Recovery-pin front end: sync + deglitch primary/secondary pins, emit edge events.
// Optional macro CLKS_ALOT_SKEW_ALIGN_EN adds a skew aligner that merges near-coincident
// primary/secondary edges into one cycle.
module clk_pin_conditioner
    import clks_alot_p::*;
    import clk_pin_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = CLK_COND_SYNC_STAGES_DEFAULT,
    parameter int unsigned FILTER_CYCLES = CLK_COND_FILTER_CYCLES_DEFAULT,
    parameter int unsigned SKEW_WINDOW   = 2
) (
    input  common_p::clk_dom_s sys_dom_i,
    input  logic               recovery_en_i,
    input  recovery_pins_s     io_clk_i,
    output driver_events_s     driver_events_o,
    output logic [1:0]         filtered_level_o,
    output logic [1:0]         glitch_o
);

    // Elaboration-time parameter range guards.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES out of range 2..4");
    end
    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_filter
        $error("FILTER_CYCLES out of range 1..255");
    end
    if (SKEW_WINDOW < 1 || SKEW_WINDOW >= (1 << SKEW_CNT_W)) begin : g_bad_skew
        $error("SKEW_WINDOW out of range 1..15");
    end

    logic clk;
    logic rst_n;
    assign clk   = sys_dom_i.clk;
    assign rst_n = sys_dom_i.rst_n;

    clk_pin_conditioner_if pri_if ();
    clk_pin_conditioner_if sec_if ();

    clk_pin_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_pri_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (recovery_en_i),
        .pin_i  (io_clk_i.primary),
        .evt_if (pri_if)
    );

    clk_pin_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_sec_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (recovery_en_i),
        .pin_i  (io_clk_i.secondary),
        .evt_if (sec_if)
    );

    // iss_c[0] = primary {rise, fall}, iss_c[1] = secondary {rise, fall} to be registered.
    logic [1:0][1:0] iss_c;
    driver_events_s  ev_d, ev_q;

`ifdef CLKS_ALOT_SKEW_ALIGN_EN
    // At most one edge is ever pending: a second-pin edge always resolves it.
    logic                  pend_vld_q, pend_vld_d;
    logic                  pend_pin_q, pend_pin_d;
    edge_pair_t            pend_ev_q,  pend_ev_d;
    logic [SKEW_CNT_W-1:0] pend_cnt_q, pend_cnt_d;
    logic [1:0][1:0]       new_ev;
    logic                  new_pin;

    // Aligner: pair edges within the window, flush on re-edge or expiry.
    always_comb begin
        new_ev[0]  = {pri_if.evt.rise_c, pri_if.evt.fall_c};
        new_ev[1]  = {sec_if.evt.rise_c, sec_if.evt.fall_c};
        new_pin    = (new_ev[0] == 2'b00);
        iss_c      = '0;
        pend_vld_d = pend_vld_q;
        pend_pin_d = pend_pin_q;
        pend_ev_d  = pend_ev_q;
        pend_cnt_d = pend_cnt_q;
        if (!recovery_en_i) begin
            pend_vld_d = 1'b0;
            pend_cnt_d = '0;
        end else if ((|new_ev[0]) && (|new_ev[1])) begin
            iss_c = new_ev;
            if (pend_vld_q) begin
                iss_c[pend_pin_q] = iss_c[pend_pin_q] | pend_ev_q;
            end
            pend_vld_d = 1'b0;
        end else if ((|new_ev[0]) || (|new_ev[1])) begin
            if (pend_vld_q && (pend_pin_q != new_pin)) begin
                iss_c[new_pin]    = new_ev[new_pin];
                iss_c[pend_pin_q] = pend_ev_q;
                pend_vld_d        = 1'b0;
            end else begin
                if (pend_vld_q) begin
                    iss_c[pend_pin_q] = pend_ev_q;
                end
                pend_vld_d = 1'b1;
                pend_pin_d = new_pin;
                pend_ev_d  = new_ev[new_pin];
                pend_cnt_d = SKEW_CNT_W'(SKEW_WINDOW);
            end
        end else if (pend_vld_q) begin
            if (pend_cnt_q <= SKEW_CNT_W'(1)) begin
                iss_c[pend_pin_q] = pend_ev_q;
                pend_vld_d        = 1'b0;
            end else begin
                pend_cnt_d = pend_cnt_q - SKEW_CNT_W'(1);
            end
        end
    end

    // Aligner pending state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_q <= 1'b0;
            pend_pin_q <= 1'b0;
            pend_ev_q  <= '0;
            pend_cnt_q <= '0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_pin_q <= pend_pin_d;
            pend_ev_q  <= pend_ev_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end
`else
    // Filter strobes feed the event register directly.
    always_comb begin
        iss_c[0] = {pri_if.evt.rise_c, pri_if.evt.fall_c};
        iss_c[1] = {sec_if.evt.rise_c, sec_if.evt.fall_c};
    end
`endif

    // Map per-pin strobes onto the event bus.
    always_comb begin
        ev_d                        = '0;
        ev_d.primary_rising_edge    = iss_c[0][1];
        ev_d.primary_falling_edge   = iss_c[0][0];
        ev_d.primary_either_edge    = |iss_c[0];
        ev_d.secondary_rising_edge  = iss_c[1][1];
        ev_d.secondary_falling_edge = iss_c[1][0];
        ev_d.secondary_either_edge  = |iss_c[1];
    end

    // Event output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_q <= '0;
        end else begin
            ev_q <= ev_d;
        end
    end

    assign driver_events_o  = ev_q;
    assign filtered_level_o = {sec_if.evt.level, pri_if.evt.level};
    assign glitch_o         = {sec_if.evt.glitch, pri_if.evt.glitch};

endmodule

// File: tb/tb_clk_pin_conditioner.sv
// Bench for clk_pin_conditioner: per-cycle model compare plus directed latency/count checks.
module tb_clk_pin_conditioner;
    import clks_alot_p::*;
    import clk_pin_conditioner_pkg::*;

    localparam int SYNC = 2;
    localparam int FC   = 3;
    localparam int LAT  = SYNC + FC;
`ifdef CLKS_ALOT_SKEW_ALIGN_EN
    localparam int SOLO_EXTRA = 2;
`else
    localparam int SOLO_EXTRA = 0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    recovery_pins_s     pins;
    common_p::clk_dom_s sys_dom;
    driver_events_s     ev;
    logic [1:0]         lvl;
    logic [1:0]         gl;

    always #5 clk = ~clk;

    assign sys_dom.clk   = clk;
    assign sys_dom.rst_n = rst_n;

    clk_pin_conditioner #(
        .SYNC_STAGES   (SYNC),
        .FILTER_CYCLES (FC),
        .SKEW_WINDOW   (2)
    ) dut (
        .sys_dom_i        (sys_dom),
        .recovery_en_i    (en),
        .io_clk_i         (pins),
        .driver_events_o  (ev),
        .filtered_level_o (lvl),
        .glitch_o         (gl)
    );

    // Expected per-pin results, held in the same bundle shape the design uses.
    clk_pin_conditioner_if exp_p ();
    clk_pin_conditioner_if exp_s ();

    int nchk = 0;
    int nerr = 0;
    int ecount = 0;
    int pcnt [6];
    int plast [6];
    int gcnt [2];

    // Model state: delay line per pin, accepted level, disagreement run length.
    bit dl [2][SYNC];
    bit m_lvl [2];
    int run_len [2];
    bit just_acc [2];
    bit xr [2];
    bit xf [2];
    bit xg [2];

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", nm, ecount, act, exp);
        end
    endtask

    task automatic model_publish();
        exp_p.evt.rise_c = xr[0];
        exp_p.evt.fall_c = xf[0];
        exp_p.evt.glitch = xg[0];
        exp_p.evt.level  = m_lvl[0];
        exp_s.evt.rise_c = xr[1];
        exp_s.evt.fall_c = xf[1];
        exp_s.evt.glitch = xg[1];
        exp_s.evt.level  = m_lvl[1];
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < SYNC; i++) dl[p][i] = 1'b0;
            m_lvl[p] = 1'b0;
            run_len[p] = 0;
            just_acc[p] = 1'b0;
            xr[p] = 1'b0;
            xf[p] = 1'b0;
            xg[p] = 1'b0;
        end
        model_publish();
    endtask

    // One clock edge of the reference behaviour, using the inputs present at that edge.
    task automatic model_step();
        bit s;
        bit pin;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int p = 0; p < 2; p++) begin
            pin = (p == 0) ? pins.primary : pins.secondary;
            s = dl[p][SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) dl[p][i] = dl[p][i-1];
            dl[p][0] = pin;
            if (!en) begin
                m_lvl[p] = s;
                run_len[p] = 0;
                just_acc[p] = 1'b0;
                xr[p] = 1'b0;
                xf[p] = 1'b0;
                xg[p] = 1'b0;
            end else begin
                xr[p] = just_acc[p] && m_lvl[p];
                xf[p] = just_acc[p] && !m_lvl[p];
                just_acc[p] = 1'b0;
                xg[p] = 1'b0;
                if (s == m_lvl[p]) begin
                    xg[p] = (run_len[p] > 0);
                    run_len[p] = 0;
                end else if (run_len[p] + 1 == FC) begin
                    m_lvl[p] = s;
                    run_len[p] = 0;
                    just_acc[p] = 1'b1;
                end else begin
                    run_len[p]++;
                end
            end
        end
        model_publish();
    endtask

    task automatic compare_all();
`ifndef CLKS_ALOT_SKEW_ALIGN_EN
        chk("pri_rise",   ev.primary_rising_edge,    exp_p.evt.rise_c);
        chk("pri_fall",   ev.primary_falling_edge,   exp_p.evt.fall_c);
        chk("pri_either", ev.primary_either_edge,    exp_p.evt.rise_c | exp_p.evt.fall_c);
        chk("sec_rise",   ev.secondary_rising_edge,  exp_s.evt.rise_c);
        chk("sec_fall",   ev.secondary_falling_edge, exp_s.evt.fall_c);
        chk("sec_either", ev.secondary_either_edge,  exp_s.evt.rise_c | exp_s.evt.fall_c);
`endif
        chk("pri_level",  lvl[0], exp_p.evt.level);
        chk("sec_level",  lvl[1], exp_s.evt.level);
        chk("pri_glitch", gl[0],  exp_p.evt.glitch);
        chk("sec_glitch", gl[1],  exp_s.evt.glitch);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 6; i++) begin
            pcnt[i] = 0;
            plast[i] = -1;
        end
        gcnt[0] = 0;
        gcnt[1] = 0;
    endtask

    task automatic tick();
        logic [5:0] b;
        @(posedge clk);
        #1;
        ecount++;
        model_step();
        compare_all();
        b = {ev.secondary_either_edge, ev.primary_either_edge, ev.secondary_falling_edge,
             ev.secondary_rising_edge, ev.primary_falling_edge, ev.primary_rising_edge};
        for (int i = 0; i < 6; i++) begin
            if (b[i]) begin
                pcnt[i]++;
                plast[i] = ecount;
            end
        end
        if (gl[0]) gcnt[0]++;
        if (gl[1]) gcnt[1]++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int samp;
        rst_n = 1'b1;
        en = 1'b0;
        pins = '0;
        model_reset();
        clear_counts();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("reset_events", int'(ev), 0);
        chk("reset_levels", int'(lvl), 0);
        chk("reset_glitch", int'(gl), 0);
        ticks(3);
        rst_n = 1'b1;
        en = 1'b1;
        ticks(5);

        // Mid-run reset with pins idle.
        clear_counts();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_events", int'(ev), 0);
        ticks(2);
        rst_n = 1'b1;
        ticks(10);
        chk("idle_pulses", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3], 0);

        // Clean rising then falling edge on primary.
        clear_counts();
        pins.primary = 1'b1;
        samp = ecount + 1;
        ticks(20);
        chk("clean_rise_count", pcnt[0], 1);
        chk("clean_either_count", pcnt[4], 1);
        chk("clean_rise_latency", plast[0] - samp, LAT + SOLO_EXTRA);
        chk("clean_rise_either_same", plast[4], plast[0]);
        chk("clean_level_hi", lvl[0], 1);
        clear_counts();
        pins.primary = 1'b0;
        samp = ecount + 1;
        ticks(20);
        chk("clean_fall_count", pcnt[1], 1);
        chk("clean_fall_latency", plast[1] - samp, LAT + SOLO_EXTRA);
        chk("clean_level_lo", lvl[0], 0);

        // Two-cycle glitch on secondary.
        clear_counts();
        pins.secondary = 1'b1;
        ticks(2);
        pins.secondary = 1'b0;
        ticks(10);
        chk("glitch_pulses", gcnt[1], 1);
        chk("glitch_no_edge", pcnt[2] + pcnt[3], 0);
        chk("glitch_level", lvl[1], 0);

        // Toggling while disabled, then enable with primary already high.
        en = 1'b0;
        pins.primary = 1'b1;
        ticks(6);
        pins.primary = 1'b0;
        ticks(6);
        pins.primary = 1'b1;
        ticks(6);
        clear_counts();
        en = 1'b1;
        ticks(15);
        chk("enable_no_pulse", pcnt[0] + pcnt[1], 0);
        chk("enable_level", lvl[0], 1);
        clear_counts();
        pins.primary = 1'b0;
        samp = ecount + 1;
        ticks(15);
        chk("enable_fall_count", pcnt[1], 1);
        chk("enable_fall_latency", plast[1] - samp, LAT + SOLO_EXTRA);

        // Disable mid-filter: level snaps, no pulse.
        clear_counts();
        pins.primary = 1'b1;
        ticks(3);
        en = 1'b0;
        ticks(5);
        en = 1'b1;
        ticks(10);
        chk("midfilt_no_pulse", pcnt[0] + pcnt[1], 0);
        chk("midfilt_level", lvl[0], 1);

        // Differential transitions in the same cycle.
        clear_counts();
        pins.primary = 1'b0;
        pins.secondary = 1'b1;
        samp = ecount + 1;
        ticks(15);
        chk("diff1_count", pcnt[1] + pcnt[2], 2);
        chk("diff1_coincident", plast[1], plast[2]);
        chk("diff1_latency", plast[1] - samp, LAT);
        clear_counts();
        pins.primary = 1'b1;
        pins.secondary = 1'b0;
        ticks(15);
        chk("diff2_count", pcnt[0] + pcnt[3], 2);
        chk("diff2_coincident", plast[0], plast[3]);

        // Toggling every cycle: 12 samples 0,1,0,1,... against level 1.
        clear_counts();
        for (int i = 0; i < 12; i++) begin
            pins.primary = ~pins.primary;
            tick();
        end
        ticks(10);
        chk("toggle_no_edge", pcnt[0] + pcnt[1], 0);
        chk("toggle_glitches", gcnt[0], 6);
        chk("toggle_level", lvl[0], 1);

        // Secondary lagging primary by 1 cycle, then by 4 cycles.
        pins.primary = 1'b0;
        ticks(20);
        clear_counts();
        pins.primary = 1'b1;
        samp = ecount + 1;
        tick();
        pins.secondary = 1'b1;
        ticks(20);
        chk("lag1_pri_latency", plast[0] - samp, LAT + (SOLO_EXTRA > 0 ? 1 : 0));
        chk("lag1_sec_latency", plast[2] - samp, LAT + 1);
        clear_counts();
        pins.primary = 1'b0;
        samp = ecount + 1;
        ticks(4);
        pins.secondary = 1'b0;
        ticks(20);
        chk("lag4_pri_latency", plast[1] - samp, LAT + SOLO_EXTRA);
        chk("lag4_sec_latency", plast[3] - samp, 4 + LAT + SOLO_EXTRA);
        chk("lag4_counts", pcnt[1] + pcnt[3], 2);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
